// File: rtl/route_sel_encoder.sv
// Route-request mask to bit-reversed 3-bit select code sequencer, one beat per set bit.
// Optional macro ROUTE_SEL_ENC_RR_EN: round-robin served index via a persistent rr_ptr.
module route_sel_encoder #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_mask,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_code,
  output logic             out_last,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic             rdy_q;
  logic [7:0]       mask_q, mask_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       sel_idx;
  logic             last_beat;
  logic             hs_out;
  logic             acc;

`ifdef ROUTE_SEL_ENC_RR_EN
  logic [2:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    logic       found;
    logic [2:0] pos;
    sel_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < 8; k++) begin
      pos = rr_ptr_q + 3'd1 + 3'(k);
      if (!found && mask_q[pos]) begin
        sel_idx = pos;
        found   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int k = 7; k >= 0; k--) begin
      if (mask_q[k]) sel_idx = 3'(k);
    end
  end
`endif

  assign last_beat = ($countones(mask_q) == 1);
  assign out_valid = (state_q == BUSY);
  // Decoder downstream expects the index with its bit order reversed.
  assign out_code  = out_valid ? {sel_idx[0], sel_idx[1], sel_idx[2]} : 3'b000;
  assign out_last  = out_valid & last_beat;
  assign out_tag   = tag_q;
  assign hs_out    = out_valid & out_ready;
  assign in_ready  = rdy_q & ((state_q == IDLE) | (hs_out & out_last));
  assign acc       = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    tag_d   = tag_q;
`ifdef ROUTE_SEL_ENC_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (acc && (in_mask != 8'h00)) begin
          mask_d  = in_mask;
          tag_d   = in_tag;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (hs_out) begin
          mask_d = mask_q & ~(8'b1 << sel_idx);
`ifdef ROUTE_SEL_ENC_RR_EN
          rr_ptr_d = sel_idx;
`endif
          if (last_beat) begin
            // Final beat: a mask accepted in the same cycle loads with no bubble.
            if (acc && (in_mask != 8'h00)) begin
              mask_d = in_mask;
              tag_d  = in_tag;
            end else begin
              mask_d  = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      mask_q  <= '0;
      tag_q   <= '0;
`ifdef ROUTE_SEL_ENC_RR_EN
      rr_ptr_q <= 3'd7;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      mask_q  <= mask_d;
      tag_q   <= tag_d;
`ifdef ROUTE_SEL_ENC_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_route_sel_encoder.sv
// Self-checking bench for route_sel_encoder: queue-based reference model plus directed literal checks.
module tb_route_sel_encoder;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_mask;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_code;
  logic             out_last;
  logic [TAG_W-1:0] out_tag;

  route_sel_encoder #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_last(out_last), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the remaining beats of the current mask as an ordered index list.
  int               mq[$];
  logic [TAG_W-1:0] m_tag = '0;
  bit               m_rel = 1'b0;
  int               m_rr = 7;

  function automatic logic [2:0] enc(input int i);
    logic [2:0] b;
    b = 3'(i);
    return {b[0], b[1], b[2]};
  endfunction

  function automatic bit e_valid();
    return mq.size() > 0;
  endfunction

  function automatic bit e_ready();
    return m_rel && (mq.size() == 0 || (mq.size() == 1 && out_ready));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit hs, acc;
    int start;
    if (!rst_n) begin
      mq.delete();
      m_tag = '0;
      m_rel = 1'b0;
      m_rr  = 7;
    end else begin
      hs  = e_valid() && out_ready;
      acc = in_valid && e_ready();
      if (hs) begin
        m_rr = mq[0];
        void'(mq.pop_front());
      end
      if (acc && in_mask != 8'h00) begin
`ifdef ROUTE_SEL_ENC_RR_EN
        start = (m_rr + 1) % 8;
`else
        start = 0;
`endif
        for (int k = 0; k < 8; k++)
          if (in_mask[(start + k) % 8]) mq.push_back((start + k) % 8);
        m_tag = in_tag;
      end
      m_rel = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, e_valid());
    chk("out_code", out_code, e_valid() ? enc(mq[0]) : 3'd0);
    chk("out_last", out_last, e_valid() && mq.size() == 1);
    chk("out_tag", out_tag, m_tag);
    chk("in_ready", in_ready, e_ready());
  end

  int log_code[$];
  int log_last[$];
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      log_code.push_back(int'(out_code));
      log_last.push_back(int'(out_last));
    end
  end

  int rmode = 0;
  int pc = 0;
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[3 - (pc % 4)]; pc++; end
        default: out_ready = 1'($urandom);
      endcase
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] m, input logic [7:0] t);
    bit r;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_mask  = m;
    in_tag   = t;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 100);
    if (!r) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (log_code.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("beat_count", log_code.size(), n);
  endtask

  task automatic chk_log(input string nm, input int codes[8], input int lasts[8], input int n);
    for (int i = 0; i < n; i++) begin
      if (i < log_code.size()) begin
        chk({nm, "_code"}, log_code[i], codes[i]);
        chk({nm, "_last"}, log_last[i], lasts[i]);
      end else begin
        chk({nm, "_missing"}, 0, 1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_mask  = '0;
    in_tag   = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_high", in_ready, 1);
    align();

    // 0x13 with tag 0x5A: codes 000,100,001
    log_code.delete(); log_last.delete();
    send(8'h13, 8'h5A);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_in_ready_busy", in_ready, 0);
    chk("t1_first_valid", out_valid, 1);
    chk("t1_tag", out_tag, 8'h5A);
    wait_beats(3);
    chk_log("t1", '{0, 4, 1, 0, 0, 0, 0, 0}, '{0, 0, 1, 0, 0, 0, 0, 0}, 3);
    align();

    // 0x80 then 0x01 back-to-back
    log_code.delete(); log_last.delete();
    send(8'h80, 8'h11);
    send(8'h01, 8'h22);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_nobubble_valid", out_valid, 1);
    chk("t2_nobubble_code", out_code, 0);
    chk("t2_nobubble_tag", out_tag, 8'h22);
    wait_beats(2);
    chk_log("t2", '{7, 0, 0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0, 0}, 2);
    align();

    // 0xFF with out_ready pattern 1,0,0,1
    log_code.delete(); log_last.delete();
    pc = 0; rmode = 1;
    send(8'hFF, 8'h33);
    in_valid = 1'b0;
    wait_beats(8);
    chk_log("t3", '{0, 4, 2, 6, 1, 5, 3, 7}, '{0, 0, 0, 0, 0, 0, 0, 1}, 8);
    align();
    rmode = 0;
    align();

    // zero mask dropped, then 0x04
    log_code.delete(); log_last.delete();
    send(8'h00, 8'h44);
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t4_zero_ready", in_ready, 1);
      chk("t4_zero_valid", out_valid, 0);
    end
    align();
    send(8'h04, 8'h55);
    in_valid = 1'b0;
    wait_beats(1);
    chk_log("t4", '{2, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0}, 1);
    align();

    // reset mid-mask abandons remaining beats
    log_code.delete(); log_last.delete();
    send(8'h0F, 8'h66);
    in_valid = 1'b0;
    wait_beats(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_code", out_code, 0);
    chk("t5_rst_last", out_last, 0);
    chk("t5_rst_ready", in_ready, 0);
    chk("t5_rst_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_post_valid", out_valid, 0);
    end
    chk("t5_beats_after_rst", log_code.size(), 2);
    align();

    // pointer behaviour right after reset: 0x06 then 0x09
    log_code.delete(); log_last.delete();
    send(8'h06, 8'h77);
    in_valid = 1'b0;
    wait_beats(2);
    align();
    send(8'h09, 8'h88);
    in_valid = 1'b0;
    wait_beats(4);
`ifdef ROUTE_SEL_ENC_RR_EN
    chk_log("t6", '{4, 2, 6, 0, 0, 0, 0, 0}, '{0, 1, 0, 1, 0, 0, 0, 0}, 4);
`else
    chk_log("t6", '{4, 2, 0, 6, 0, 0, 0, 0}, '{0, 1, 0, 1, 0, 0, 0, 0}, 4);
`endif
    align();

    // randomized traffic against the model
    rmode = 2;
    repeat (600) begin
      in_valid = 1'($urandom);
      in_mask  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      in_tag   = 8'($urandom);
      align();
    end
    in_valid = 1'b0;
    rmode = 0;
    repeat (20) align();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
